mem_bus_if: RTL

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_bus_arb.sv | 25 ++
 rtl/mem_bus_if.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the cache-to-memory bus interface.
package mem_bus_pkg;

    localparam int LINE_WORDS       = 8;
    localparam int OFFSET_W         = 3;
    localparam int LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        FILL,
        GAP
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Bit positions within the arbiter's one-hot grant vector.
    localparam int GNT_IC = 0;
    localparam int GNT_DR = 1;
    localparam int GNT_DW = 2;

endpackage

// File: rtl/mem_bus_arb.sv
// Fixed-priority arbiter: D$ write beats D$ line fill beats I$ line fill.
module mem_bus_arb
    import mem_bus_pkg::*;
(
    input  logic       ic_req,
    input  logic       dc_rd_req,
    input  logic       dc_wr_req,
    input  logic       en,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (en) begin
            if (dc_wr_req) begin
                grant[GNT_DW] = 1'b1;
            end else if (dc_rd_req) begin
                grant[GNT_DR] = 1'b1;
            end else if (ic_req) begin
                grant[GNT_IC] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_if.sv
// Memory bus interface shared by I$ and D$: single-word write-through and
// burst line fills, with a two-cycle idle gap after every transaction.
module mem_bus_if
    import mem_bus_pkg::*;
#(
    parameter int LINE_WORDS = mem_bus_pkg::LINE_WORDS,
    parameter int ADDR_W     = 32
) (
    input  logic                CLK,
    input  logic                MRST_N,
    input  logic                ic_req,
    input  logic [ADDR_W-1:0]   ic_addr,
    output logic                ic_done,
    input  logic                dc_rd_req,
    input  logic                dc_wr_req,
    input  logic [ADDR_W-1:0]   dc_addr,
    input  logic [ADDR_W-1:0]   dc_wdata,
    output logic                dc_done,
    output logic                fill_valid,
    output logic                fill_owner,
    output logic [OFFSET_W-1:0] fill_idx,
    output logic [ADDR_W-1:0]   fill_word,
    output logic [ADDR_W-1:0]   Addr,
    output logic                Read,
    output logic                Write,
    output logic [ADDR_W-1:0]   BusOut,
    output logic                BusOE,
    input  logic [ADDR_W-1:0]   BusIn,
    input  logic                Valid
);

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

    state_t              state_q, state_d;
    logic [OFFSET_W-1:0] beat_q;
    logic                gap_q;
    logic                owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   wdata_q;
    logic [2:0]          grant;
    logic                beat;
    logic                last_beat;

    mem_bus_arb u_arb (
        .ic_req    (ic_req),
        .dc_rd_req (dc_rd_req),
        .dc_wr_req (dc_wr_req),
        .en        (state_q == IDLE),
        .grant     (grant)
    );

    assign beat      = (state_q == FILL) && Valid;
    assign last_beat = beat && (beat_q == OFFSET_W'(LINE_WORDS - 1));

    always_comb begin
        state_d = state_q;
        Read    = 1'b0;
        Write   = 1'b0;
        BusOE   = 1'b0;
        Addr    = '0;
        BusOut  = '0;
        unique case (state_q)
            IDLE: begin
                if (grant[GNT_DW]) begin
                    state_d = WR;
                end else if (grant != '0) begin
                    state_d = FILL;
                end
            end
            WR: begin
                Write   = 1'b1;
                BusOE   = 1'b1;
                Addr    = addr_q;
                BusOut  = wdata_q;
                state_d = GAP;
            end
            FILL: begin
                Read = 1'b1;
                Addr = addr_q;
                if (last_beat) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!MRST_N) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            gap_q      <= 1'b0;
            owner_q    <= OWN_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            fill_valid <= 1'b0;
            fill_owner <= OWN_I;
            fill_idx   <= '0;
            fill_word  <= '0;
            ic_done    <= 1'b0;
            dc_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= (state_q == GAP) && !gap_q;
            fill_valid <= beat;
            // Done is registered so it lines up with the last fill word.
            ic_done    <= last_beat && (owner_q == OWN_I);
            dc_done    <= (last_beat && (owner_q == OWN_D)) || (state_q == WR);
            if (beat) begin
                beat_q     <= last_beat ? '0 : beat_q + 1'b1;
                fill_word  <= BusIn;
                fill_idx   <= beat_q;
                fill_owner <= owner_q;
            end
            if ((state_q == IDLE) && (grant != '0)) begin
                owner_q <= grant[GNT_IC] ? OWN_I : OWN_D;
                wdata_q <= dc_wdata;
                if (grant[GNT_DW]) begin
                    addr_q <= dc_addr;
                end else if (grant[GNT_DR]) begin
                    addr_q <= dc_addr & LINE_MASK;
                end else begin
                    addr_q <= ic_addr & LINE_MASK;
                end
            end
        end
    end

endmodule
